// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load scoreboard, load-use/WAW stalls, memory-wait stalls and redirect flush bubbles.
// Optional cycle counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int NREG         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            rs1_r_ena,
    input  logic [4:0]      rs1_r_addr,
    input  logic            rs2_r_ena,
    input  logic [4:0]      rs2_r_addr,
    input  logic            rd_w_ena,
    input  logic [4:0]      rd_w_addr,
    input  logic            mem_rd_ena,
    input  logic            redirect,
    input  logic            mem_busy,
    input  logic            wb_load_valid,
    input  logic [4:0]      wb_load_rd,
    output logic            id_issue,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_id,
    output logic            flush_ex,
    output logic [NREG-1:0] sb_busy,
    output logic [1:0]      ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_haz_cnt,
    output logic [31:0]     perf_mem_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NREG-1:0] sb_q, sb_d, sb_set, sb_clr;
    logic [31:0]     sb_pad, eff;
    logic            hazard;
    logic            issue_c, stall_c, flush_id_c, flush_ex_c;
    logic            haz_stall_c, mem_stall_c;

    // Widen the scoreboard to the full 5-bit register address space.
    if (NREG < 32) begin : g_pad
        assign sb_pad = {{(32 - NREG){1'b0}}, sb_q};
    end else begin : g_nopad
        assign sb_pad = sb_q[31:0];
    end

    // A writeback this cycle releases its register immediately (write-through regfile).
    always_comb begin
        eff = '0;
        for (int i = 0; i < 32; i++) begin
            eff[i] = sb_pad[i] & ~(wb_load_valid && (wb_load_rd == 5'(i)));
        end
    end

    always_comb begin
        hazard = id_valid &
                 ((rs1_r_ena && (rs1_r_addr != 5'd0) && eff[rs1_r_addr]) ||
                  (rs2_r_ena && (rs2_r_addr != 5'd0) && eff[rs2_r_addr]) ||
                  (rd_w_ena  && (rd_w_addr  != 5'd0) && eff[rd_w_addr]));
    end

    // Priority: redirect > flush countdown > mem_busy > hazard > issue.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_c     = 1'b0;
        stall_c     = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        haz_stall_c = 1'b0;
        mem_stall_c = 1'b0;
        if (redirect) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
            state_d    = ST_FLUSH;
            cnt_d      = FLUSH_LOAD;
        end else if (state_q == ST_FLUSH) begin
            flush_id_c = 1'b1;
            if (cnt_q == 3'd0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (mem_busy) begin
            stall_c     = 1'b1;
            mem_stall_c = 1'b1;
            state_d     = ST_MEM;
        end else if (hazard) begin
            stall_c     = 1'b1;
            flush_ex_c  = 1'b1;
            haz_stall_c = 1'b1;
            state_d     = ST_HAZ;
        end else begin
            issue_c = id_valid;
            state_d = ST_RUN;
        end
    end

    // Set wins over a same-cycle clear; x0 is never tracked.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        for (int i = 1; i < NREG; i++) begin
            sb_set[i] = issue_c & mem_rd_ena & rd_w_ena & (rd_w_addr == 5'(i));
            sb_clr[i] = wb_load_valid & (wb_load_rd == 5'(i));
        end
        sb_d = (sb_q & ~sb_clr) | sb_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sb_q    <= sb_d;
        end
    end

    assign id_issue   = issue_c    & ~rst;
    assign stall_if   = stall_c    & ~rst;
    assign stall_id   = stall_c    & ~rst;
    assign flush_id   = flush_id_c & ~rst;
    assign flush_ex   = flush_ex_c & ~rst;
    assign sb_busy    = sb_q;
    assign ctrl_state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_haz_cnt   <= '0;
            perf_mem_cnt   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (haz_stall_c && (perf_haz_cnt != 32'hFFFF_FFFF)) begin
                perf_haz_cnt <= perf_haz_cnt + 32'd1;
            end
            if (mem_stall_c && (perf_mem_cnt != 32'hFFFF_FFFF)) begin
                perf_mem_cnt <= perf_mem_cnt + 32'd1;
            end
            if (flush_id_c && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = haz_stall_c ^ mem_stall_c;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2): expected outputs queued per step, checked mid-cycle.
module tb_pipe_hazard_ctrl;

    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, mem_rd_ena;
    logic [4:0]      rs1_r_addr, rs2_r_addr, rd_w_addr, wb_load_rd;
    logic            redirect, mem_busy, wb_load_valid;
    logic            id_issue, stall_if, stall_id, flush_id, flush_ex;
    logic [NREG-1:0] sb_busy;
    logic [1:0]      ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0]     perf_haz_cnt, perf_mem_cnt, perf_flush_cnt;
`endif

    logic [6:0]      exp_q[$];
    logic [NREG-1:0] sb_exp_q[$];
    int              n_assert = 0;
    int              n_fail   = 0;

    pipe_hazard_ctrl #(.NREG(NREG), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
        .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
        .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .mem_rd_ena(mem_rd_ena),
        .redirect(redirect), .mem_busy(mem_busy),
        .wb_load_valid(wb_load_valid), .wb_load_rd(wb_load_rd),
        .id_issue(id_issue), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .sb_busy(sb_busy), .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_haz_cnt(perf_haz_cnt), .perf_mem_cnt(perf_mem_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl(input logic iss, input logic sif, input logic sid,
                                       input logic fid, input logic fex, input logic [1:0] st);
        return {iss, sif, sid, fid, fex, st};
    endfunction

    task automatic clr_in();
        id_valid = 0; rs1_r_ena = 0; rs1_r_addr = 0; rs2_r_ena = 0; rs2_r_addr = 0;
        rd_w_ena = 0; rd_w_addr = 0; mem_rd_ena = 0; redirect = 0; mem_busy = 0;
        wb_load_valid = 0; wb_load_rd = 0;
    endtask

    task automatic load(input logic [4:0] rd);
        id_valid = 1; rd_w_ena = 1; rd_w_addr = rd; mem_rd_ena = 1;
    endtask

    task automatic read_rs1(input logic [4:0] r);
        id_valid = 1; rs1_r_ena = 1; rs1_r_addr = r;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_load_valid = 1; wb_load_rd = r;
    endtask

    // Inputs are driven 1ns after a rising edge; outputs are checked 4ns later.
    task automatic run(input logic [6:0] exp_c, input logic [NREG-1:0] exp_sb, input string tag);
        logic [6:0]      e_c, obs_c;
        logic [NREG-1:0] e_sb;
        exp_q.push_back(exp_c);
        sb_exp_q.push_back(exp_sb);
        #4;
        e_c   = exp_q.pop_front();
        e_sb  = sb_exp_q.pop_front();
        obs_c = {id_issue, stall_if, stall_id, flush_id, flush_ex, ctrl_state};
        n_assert++;
        assert (obs_c === e_c) else begin
            n_fail++;
            $error("FAIL %s ctrl{issue,sif,sid,fid,fex,st}: observed=%b expected=%b", tag, obs_c, e_c);
        end
        n_assert++;
        assert (sb_busy === e_sb) else begin
            n_fail++;
            $error("FAIL %s sb_busy: observed=%h expected=%h", tag, sb_busy, e_sb);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        id_valid = 1; redirect = 1;
        run(ctl(0,0,0,0,0,0), 32'h0, "reset_outputs_zero");
        rst = 0;

        clr_in(); load(5);
        run(ctl(1,0,0,0,0,0), 32'h0, "load_x5_issue");
        clr_in(); read_rs1(5);
        run(ctl(0,1,1,0,1,0), 32'h20, "use_x5_haz1");
        clr_in(); read_rs1(5);
        run(ctl(0,1,1,0,1,1), 32'h20, "use_x5_haz2");
        clr_in(); read_rs1(5); wb(5);
        run(ctl(1,0,0,0,0,1), 32'h20, "use_x5_wb_release");
        clr_in();
        run(ctl(0,0,0,0,0,0), 32'h0, "x5_cleared");

        clr_in(); load(0);
        run(ctl(1,0,0,0,0,0), 32'h0, "load_x0");
        clr_in(); read_rs1(0); rs2_r_ena = 1; rd_w_ena = 1;
        run(ctl(1,0,0,0,0,0), 32'h0, "use_x0_no_stall");

        clr_in(); load(5);
        run(ctl(1,0,0,0,0,0), 32'h0, "load_x5_again");
        clr_in(); read_rs1(5); mem_busy = 1;
        run(ctl(0,1,1,0,0,0), 32'h20, "mem_busy_1");
        clr_in(); read_rs1(5); mem_busy = 1;
        run(ctl(0,1,1,0,0,2), 32'h20, "mem_busy_2");
        clr_in(); read_rs1(5); mem_busy = 1;
        run(ctl(0,1,1,0,0,2), 32'h20, "mem_busy_3");
        clr_in(); read_rs1(5);
        run(ctl(0,1,1,0,1,2), 32'h20, "mem_exit_hazard");

        clr_in(); read_rs1(5); mem_busy = 1; redirect = 1;
        run(ctl(0,0,0,1,1,1), 32'h20, "redirect_over_all");
        clr_in();
        run(ctl(0,0,0,1,0,3), 32'h20, "flush_1");
        clr_in();
        run(ctl(0,0,0,1,0,3), 32'h20, "flush_2");
        clr_in();
        run(ctl(0,0,0,0,0,0), 32'h20, "flush_done_run");

        clr_in(); load(7);
        run(ctl(1,0,0,0,0,0), 32'h20, "load_x7");
        clr_in(); load(7); wb(7);
        run(ctl(1,0,0,0,0,0), 32'hA0, "reload_x7_with_wb");
        clr_in(); wb(5);
        run(ctl(0,0,0,0,0,0), 32'hA0, "set_wins_x7");
        clr_in(); id_valid = 1; rd_w_ena = 1; rd_w_addr = 7;
        run(ctl(0,1,1,0,1,0), 32'h80, "waw_x7");
        clr_in(); wb(7);
        run(ctl(0,0,0,0,0,1), 32'h80, "haz_idle_wb_x7");

        clr_in(); load(5);
        run(ctl(1,0,0,0,0,0), 32'h0, "load_x5_third");
        clr_in(); id_valid = 1; rs2_r_ena = 1; rs2_r_addr = 5;
        run(ctl(0,1,1,0,1,0), 32'h20, "rs2_haz1");
        run(ctl(0,1,1,0,1,1), 32'h20, "rs2_haz2");
        rst = 1;
        run(ctl(0,0,0,0,0,0), 32'h0, "reset_mid_haz");
        rst = 0;
        run(ctl(1,0,0,0,0,0), 32'h0, "after_reset_issue");

        clr_in(); redirect = 1;
        run(ctl(0,0,0,1,1,0), 32'h0, "redirect_a");
        clr_in(); redirect = 1;
        run(ctl(0,0,0,1,1,3), 32'h0, "redirect_in_flush");
        clr_in();
        run(ctl(0,0,0,1,0,3), 32'h0, "reloaded_flush_1");
        run(ctl(0,0,0,1,0,3), 32'h0, "reloaded_flush_2");
        clr_in(); id_valid = 1;
        run(ctl(1,0,0,0,0,0), 32'h0, "reloaded_flush_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core. It sits beside the decode stage and consumes decode's register-enable/address and memory-enable outputs.
- Keeps a load scoreboard and detects load-use and WAW hazards. Sequences stalls for outstanding data-memory accesses and flush bubbles for EX-stage redirects (branch/jal/jalr).
- Drives the per-stage stall/flush controls and the decode issue strobe.

Parameters:
- NREG, 32, number of architectural integer registers; scoreboard width.
- FLUSH_CYCLES, 1, bubble cycles inserted after a redirect (1..7).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- id_valid  input  1  decode holds a valid instruction
- rs1_r_ena  input  1  decoded rs1 read enable
- rs1_r_addr  input  5  decoded rs1 index
- rs2_r_ena  input  1  decoded rs2 read enable
- rs2_r_addr  input  5  decoded rs2 index
- rd_w_ena  input  1  decoded rd write enable
- rd_w_addr  input  5  decoded rd index
- mem_rd_ena  input  1  decoded instruction is a load
- redirect  input  1  EX resolved a taken branch/jump this cycle
- mem_busy  input  1  data-memory access in MEM still outstanding
- wb_load_valid  input  1  load result written back this cycle
- wb_load_rd  input  5  register of that load result
- id_issue  output  1  decode instruction advances to EX this cycle
- stall_if  output  1  hold PC/IF register
- stall_id  output  1  hold IF/ID register
- flush_id  output  1  squash IF/ID contents
- flush_ex  output  1  squash ID/EX contents (insert bubble)
- sb_busy  output  NREG  scoreboard vector (debug/diff-test)
- ctrl_state  output  2  FSM state encoding

Behaviour:
- States: RUN=0, HAZ=1, MEM=2, FLUSH=3.
- Reset (async): state=RUN, sb_busy=0, flush counter=0. While rst=1, all outputs are 0.
- Outputs are Mealy: combinational from state plus current inputs. State and scoreboard update on the clk rising edge.
- Effective busy: eff[r] = sb_busy[r] & ~(wb_load_valid & wb_load_rd==r). A same-cycle writeback releases the hazard; the register file writes through.
- hazard = id_valid & ((rs1_r_ena & rs1_r_addr!=0 & eff[rs1_r_addr]) | (rs2_r_ena & rs2_r_addr!=0 & eff[rs2_r_addr]) | (rd_w_ena & rd_w_addr!=0 & eff[rd_w_addr])).
- Priority each cycle: redirect > mem_busy > hazard > issue.
- redirect in any state:
  - same cycle: flush_id=1, flush_ex=1, id_issue=0.
  - next state FLUSH, counter loaded with FLUSH_CYCLES-1.
- FLUSH:
  - flush_id=1, id_issue=0.
  - counter decrements; exits to RUN after it reaches 0 (FLUSH_CYCLES bubbles in total, counting the redirect cycle's successors).
  - a redirect arriving during FLUSH reloads the counter.
- mem_busy=1 (no redirect):
  - stall_if=stall_id=1, flush_ex=0, id_issue=0, state MEM.
  - ID/EX is held by the downstream stall, not bubbled.
  - leave MEM in the first cycle mem_busy=0, re-evaluating hazard that same cycle.
- hazard (no redirect, no mem_busy):
  - stall_if=stall_id=1, flush_ex=1 (bubble into EX), id_issue=0, state HAZ.
  - remain in HAZ while hazard holds; return to RUN in the cycle hazard drops, issuing in that cycle.
- Issue: id_issue = id_valid & no redirect/mem_busy/hazard; the state is RUN at the next edge.
- Scoreboard set: id_issue & mem_rd_ena & rd_w_ena & rd_w_addr!=0 sets sb_busy[rd_w_addr].
- Scoreboard clear: wb_load_valid clears sb_busy[wb_load_rd].
- Set and clear of the same register in the same cycle: set wins.
- Bit 0 is never set.
- Load issue while a redirect is active cannot happen, because id_issue=0.
- Redirect does not clear the scoreboard; older loads still complete.
- Reset asserted mid-stall returns the block to RUN with an empty scoreboard immediately.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - adds outputs perf_haz_cnt, perf_mem_cnt, perf_flush_cnt (each 32 bits).
  - each counts cycles with the state/condition that drives the corresponding stall or flush.
  - saturating at 32'hFFFF_FFFF; async reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load rd=5 issued, next instruction has rs1=5 and wb_load_valid=0 for 2 cycles:
  - HAZ for 2 cycles with stall_if=stall_id=flush_ex=1.
  - the cycle wb_load_valid=1 with wb_load_rd=5 gives id_issue=1 and sb_busy[5] cleared.
- Load to rd=0, then an instruction reading x0: sb_busy stays 0 and there is no stall.
- mem_busy high for 3 cycles with a pending hazard: MEM for 3 cycles with flush_ex=0; then HAZ is evaluated on the 4th cycle.
- redirect coincident with mem_busy and hazard, FLUSH_CYCLES=2:
  - flush_id=flush_ex=1 in the same cycle.
  - FLUSH for 2 cycles, then RUN.
- wb_load_valid clears rd=7 in the same cycle a new load to rd=7 issues: sb_busy[7]=1 afterwards.
- Assert rst while in HAZ with sb_busy=0x0000_0020: all outputs 0 immediately, state=RUN; after release, sb_busy=0.
